// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART transmit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int DEF_TIMEOUT_CYC = 100_000;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  // Adds off (< n) to base (< n) and wraps modulo n without a divider.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin select: first set request at or after
//            i_rr_ptr, wrapping modulo N_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_rr_ptr,
  output logic [N_REQ-1:0]         o_onehot,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_valid
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] w_slot [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_slot
    assign w_slot[k] = IW'(rr_wrap(int'(i_rr_ptr), k, N_REQ));
  end

  // Scan farthest slot first so the slot nearest the pointer overwrites last.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[w_slot[k]]) begin
        o_onehot            = '0;
        o_onehot[w_slot[k]] = 1'b1;
        o_idx               = w_slot[k];
        o_valid             = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one UART transmitter among N_REQ byte
//            producers. Optional Tx_Done watchdog under macro TX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 8
`ifdef TX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      req_data,
  output logic [N_REQ-1:0]         ack,
  input  logic [2:0]               baud_set_in,
  output logic [2:0]               baud_set,
  output logic [DW-1:0]            data_byte,
  output logic                     send_en,
  input  logic                     Tx_Done,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] gnt_idx
`ifdef TX_TIMEOUT_EN
  ,
  output logic                     tx_timeout
`endif
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t       r_state;
  logic [N_REQ-1:0] r_ack;
  logic             r_send_en;
  logic [DW-1:0]    r_data;
  logic             r_busy;
  logic [IW-1:0]    r_gnt;
  logic [IW-1:0]    r_rr_ptr;

  logic [N_REQ-1:0] w_onehot;
  logic [IW-1:0]    w_idx;
  logic             w_valid;
  logic [DW-1:0]    w_data;
  logic [N_REQ-1:0] w_ack_vec;
  logic [IW-1:0]    w_rr_next;

`ifdef TX_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC);
  logic           r_tx_timeout;
  logic [WDW-1:0] r_wdog;
`endif

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_onehot[i]) begin
        w_data = w_data | req_data[i*DW +: DW];
      end
    end
  end

  assign w_ack_vec = N_REQ'(1) << r_gnt;
  assign w_rr_next = IW'(rr_wrap(int'(r_gnt), 1, N_REQ));

  // send_en is registered on the SEND->WAIT edge, so it is high during the
  // first WAIT cycle; a Tx_Done in that cycle cannot belong to this frame.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= ST_IDLE;
      r_ack     <= '0;
      r_send_en <= 1'b0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_gnt     <= '0;
      r_rr_ptr  <= '0;
`ifdef TX_TIMEOUT_EN
      r_tx_timeout <= 1'b0;
      r_wdog       <= '0;
`endif
    end else begin
      r_ack     <= '0;
      r_send_en <= 1'b0;
`ifdef TX_TIMEOUT_EN
      r_tx_timeout <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_data  <= w_data;
            r_gnt   <= w_idx;
            r_busy  <= 1'b1;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_send_en <= 1'b1;
          r_state   <= ST_WAIT;
`ifdef TX_TIMEOUT_EN
          r_wdog    <= '0;
`endif
        end
        ST_WAIT: begin
          if (Tx_Done && !r_send_en) begin
            r_ack    <= w_ack_vec;
            r_rr_ptr <= w_rr_next;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
`ifdef TX_TIMEOUT_EN
          else if (r_wdog == WDW'(TIMEOUT_CYC - 1)) begin
            r_ack        <= w_ack_vec;
            r_tx_timeout <= 1'b1;
            r_rr_ptr     <= w_rr_next;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + WDW'(1);
          end
`endif
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign send_en   = r_send_en;
  assign data_byte = r_data;
  assign busy      = r_busy;
  assign gnt_idx   = r_gnt;
  assign baud_set  = baud_set_in;
`ifdef TX_TIMEOUT_EN
  assign tx_timeout = r_tx_timeout;
`endif

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (uart: data_byte/send_en in, Tx_Done out) between N_REQ byte producers.
- Round-robin arbitration; latches the winner's byte, issues a one-cycle send_en pulse, waits for Tx_Done, then acks the requester.
- Sits between producer logic (command responder, status reporter, debug dump) and the uart instance; baud_set is passed through unchanged.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DW, 8, byte width; must match uart data_byte
- TIMEOUT_CYC, 100000, watchdog limit in Clk cycles (used only with TX_TIMEOUT_EN); above one 9600-baud frame at 50 MHz (~52083)

Ports:
- Clk  in  1  system clock, 50 MHz
- Rst  in  1  asynchronous reset, active-high
- req  in  N_REQ  per-requester request level; held high with data stable until matching ack
- req_data  in  N_REQ*DW  packed bytes; requester i at bits [i*DW +: DW]
- ack  out  N_REQ  one-cycle pulse to the granted requester when its byte is finished
- baud_set_in  in  3  baud selector from config
- baud_set  out  3  to uart baud_set, combinational pass-through
- data_byte  out  DW  to uart data_byte, registered
- send_en  out  1  to uart send_en, one-cycle high pulse
- Tx_Done  in  1  from uart, one-cycle pulse at end of stop bit
- busy  out  1  high in every state except IDLE
- gnt_idx  out  clog2(N_REQ)  index of the current or last grant
- tx_timeout  out  1  one-cycle pulse on watchdog expiry (port present only with TX_TIMEOUT_EN)

Behaviour:
- Reset: state=IDLE; ack=0, send_en=0, data_byte=0, busy=0, gnt_idx=0, rr_ptr=0, tx_timeout=0, watchdog=0.
- Reset asserted mid-operation aborts immediately with no ack. A uart frame already in flight completes on the line. Any Tx_Done arriving later is ignored because the FSM is in IDLE.
- States:
  - IDLE: if |req, pick the winner = first set bit scanning from rr_ptr upward with wrap. Register data_byte <= req_data[winner], gnt_idx <= winner, go SEND. Otherwise stay.
  - SEND: send_en=1 for exactly this cycle; go WAIT.
  - WAIT: on Tx_Done, ack[gnt_idx]=1 for one cycle, rr_ptr <= (gnt_idx+1) mod N_REQ, go IDLE.
- Latency: req rise (FSM in IDLE) -> send_en 2 cycles later (edge 1 latch, edge 2 pulse). Tx_Done -> ack on the next cycle. Minimum gap between consecutive send_en pulses = 3 cycles after Tx_Done.
- Handshake:
  - Requester drops req, or presents a new byte, on the cycle after seeing ack.
  - A req still high in IDLE is a new request.
  - Because rr_ptr has moved past it, another pending requester wins first.
  - req dropping while granted does not cancel the transfer; the ack is still pulsed.
- Tx_Done is ignored in IDLE and SEND, including a Tx_Done coincident with send_en.
- data_byte holds its value until the next grant; it never changes during SEND/WAIT.
- Simultaneous requests are served strictly round-robin. No requester waits more than N_REQ-1 frames.
- rr_ptr wraps from N_REQ-1 to 0. Non-power-of-two N_REQ uses modulo, not bit truncation.

Optional Feature:
- Macro TX_TIMEOUT_EN.
- Defined:
  - Watchdog counter clears on entering WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYC-1 without Tx_Done: tx_timeout=1 and ack[gnt_idx]=1 for one cycle, rr_ptr advances, go IDLE.
  - Tx_Done in the same cycle as expiry counts as normal completion; tx_timeout=0.
- Undefined: no counter, no tx_timeout port; WAIT blocks indefinitely for Tx_Done.

Decomposition:
- Package uart_pkg: FSM state encoding (IDLE/SEND/WAIT), BAUD_9600..BAUD_115200 baud_set codes, CLK_HZ=50_000_000, default TIMEOUT_CYC.
- One sub-module, rr_pick: combinational N_REQ-wide round-robin priority select (inputs req and rr_ptr; outputs one-hot plus index plus valid). The FSM and data mux stay in uart_tx_arbiter.

Test Plan:
- Single requester: req[0]=1, data 8'h9E -> data_byte=8'h9E, send_en pulse 2 cycles after req. Bench Tx_Done model (or real uart, baud_set=4) -> ack[0] one cycle after Tx_Done; the line carries 0x9E LSB-first.
- All four request at once with 8'h11/8'h22/8'h33/8'h44, each dropping req after its ack -> send order 11,22,33,44. Exactly 4 send_en pulses and 4 acks, in index order.
- Fairness: req[0] and req[2] held high continuously with data re-presented after each ack -> grants alternate 0,2,0,2. rr_ptr wraps correctly with N_REQ=3 build.
- Spurious/edge Tx_Done: Tx_Done pulsed in IDLE and in the SEND cycle -> no ack, state unchanged. Only a WAIT-state Tx_Done produces ack.
- Reset mid-WAIT: assert Rst 100 cycles after send_en -> all outputs at reset values asynchronously. A later Tx_Done gives no ack. A fresh req after release is served from rr_ptr=0.
- TX_TIMEOUT_EN, TIMEOUT_CYC=50, Tx_Done never returned -> tx_timeout and ack[idx] pulse on WAIT cycle 50, busy drops next cycle. Tx_Done on the expiry cycle -> ack only, tx_timeout=0.
